button_debounce_repeat: RTL and testbench

- Upstream conditioning stage for the single-bit D flip-flop register stage of the user-control path.
- Takes one raw, asynchronous pushbutton input and synchronizes it to clk.
- Debounces it and produces a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Optional auto-repeat generates periodic press pulses while the button is held, e.g. for increment/decrement of settable values.

---
 rtl/button_debounce_repeat.sv | 138 +++++++++++++
 tb/tb_button_debounce_repeat.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_repeat.sv
// Pushbutton conditioner: synchronizes a raw asynchronous button input to clk,
// debounces both edges and produces a clean level, a press strobe (plus optional
// auto-repeat strobes while held) and a release strobe. All outputs are registered.
module button_debounce_repeat #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter int unsigned CNT_W           = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    // Terminal counts for the shared counter
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_PRESS,
        ST_HELD,
        ST_REPEAT,
        ST_CHK_REL
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   release_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability synchronizer chain for the raw button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Debounce / auto-repeat state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_q <= ST_CHK_PRESS;
                        cnt_q   <= '0;
                    end
                end
                ST_CHK_PRESS: begin
                    if (!s) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_q <= ST_CHK_REL;
                        cnt_q   <= '0;
                    end else if (!repeat_en) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_REPEAT;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!s) begin
                        state_q <= ST_CHK_REL;
                        cnt_q   <= '0;
                    end else if (!repeat_en) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_CHK_REL: begin
                    // A bounce back to high restarts the hold delay without a pulse
                    if (s) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat: directed scenarios with hand-computed strobe
// times, followed by a randomized bouncy sweep checked against a behavioural model.
module tb_button_debounce_repeat;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic repeat_en;
    logic btn_level;
    logic btn_pulse;
    logic btn_release;

    always #5 clk = ~clk;

    button_debounce_repeat #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release)
    );

    typedef struct {
        bit rel;   // 0 = press/repeat strobe, 1 = release strobe
        int cyc;   // edge count after which the strobe must be visible
    } ev_t;

    ev_t evq[$];
    int  total    = 0;
    int  bad      = 0;
    int  cyc      = 0;
    bit  sweep_on = 1'b0;

    // Behavioural reference state (used for the random sweep)
    bit [SYNC-1:0] m_sync   = '0;
    bit            m_level  = 1'b0;
    bit            m_prev_s = 1'b0;
    bit            m_first  = 1'b1;
    int            m_run    = 0;
    int            m_rc     = 0;
    bit            exp_level = 1'b0;

    // Edge counter and reference model: run-length of s disagreeing with the
    // level decides acceptance; a separate hold/repeat timer runs while held.
    always @(posedge clk) begin : model
        bit s;
        bit lvl0;
        bit evp;
        bit evr;
        cyc = cyc + 1;
        evp = 1'b0;
        evr = 1'b0;
        if (rst) begin
            m_sync   = '0;
            m_level  = 1'b0;
            m_prev_s = 1'b0;
            m_first  = 1'b1;
            m_run    = 0;
            m_rc     = 0;
        end else begin
            s      = m_sync[SYNC-1];
            lvl0   = m_level;
            m_sync = {m_sync[SYNC-2:0], btn_in};
            if (s != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEB + 1) begin
                    m_level = s;
                    m_run   = 0;
                    if (s) begin
                        evp     = 1'b1;
                        m_rc    = 0;
                        m_first = 1'b1;
                    end else begin
                        evr = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            if (lvl0 && s) begin
                if (!m_prev_s || !repeat_en) begin
                    m_rc    = 0;
                    m_first = 1'b1;
                end else begin
                    m_rc = m_rc + 1;
                    if (m_rc == (m_first ? HOLD : REP)) begin
                        evp     = 1'b1;
                        m_rc    = 0;
                        m_first = 1'b0;
                    end
                end
            end
            m_prev_s = s;
        end
        exp_level = m_level;
        if (sweep_on && (evp || evr)) begin
            ev_t e;
            e.rel = evr;
            e.cyc = cyc;
            evq.push_back(e);
        end
    end

    bit prev_p = 1'b0;
    bit prev_r = 1'b0;

    // Monitor: matches every DUT strobe against the expected-event queue
    always @(negedge clk) begin : monitor
        if (btn_pulse || btn_release) begin
            total = total + 1;
            if (btn_pulse && btn_release) begin
                bad = bad + 1;
                $display("FAIL exclusive: pulse=%b release=%b both high at cycle %0d", btn_pulse, btn_release, cyc);
            end
        end
        if (btn_pulse) begin
            total = total + 1;
            if (prev_p) begin
                bad = bad + 1;
                $display("FAIL pulse_width: pulse high for 2+ cycles at cycle %0d, want 1 cycle", cyc);
            end
        end
        if (btn_release) begin
            total = total + 1;
            if (prev_r) begin
                bad = bad + 1;
                $display("FAIL release_width: release high for 2+ cycles at cycle %0d, want 1 cycle", cyc);
            end
        end
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL missed_event: got nothing, want %s at cycle %0d", evq[0].rel ? "release" : "pulse", evq[0].cyc);
            void'(evq.pop_front());
        end
        if (btn_pulse || btn_release) begin
            total = total + 1;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                if (evq[0].rel != btn_release) begin
                    bad = bad + 1;
                    $display("FAIL event_kind: got pulse=%b release=%b, want %s at cycle %0d",
                             btn_pulse, btn_release, evq[0].rel ? "release" : "pulse", cyc);
                end
                void'(evq.pop_front());
            end else begin
                bad = bad + 1;
                $display("FAIL unexpected_event: got pulse=%b release=%b, want none at cycle %0d", btn_pulse, btn_release, cyc);
            end
        end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL missing_event: got none, want %s at cycle %0d", evq[0].rel ? "release" : "pulse", cyc);
            void'(evq.pop_front());
        end
        if (sweep_on) begin
            total = total + 1;
            if (btn_level !== exp_level) begin
                bad = bad + 1;
                $display("FAIL sweep_level: got %b want %b at cycle %0d", btn_level, exp_level, cyc);
            end
        end
        prev_p = btn_pulse;
        prev_r = btn_release;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit rel, input int c);
        ev_t e;
        e.rel = rel;
        e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %b want %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Directed scenarios then the randomized sweep
    initial begin : stim
        int b;
        int seg;
        rst       = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        step(3);
        chk("reset_level", btn_level, 1'b0);
        chk("reset_pulse", btn_pulse, 1'b0);
        chk("reset_release", btn_release, 1'b0);
        rst = 1'b0;
        step(2);

        // Clean press: strobe after edge 7, no repeat while repeat_en is low
        b = cyc;
        btn_in = 1'b1;
        push(1'b0, b + 7);
        step(6);
        chk("press_level_before", btn_level, 1'b0);
        step(1);
        chk("press_level", btn_level, 1'b1);
        step(10);
        chk("held_level", btn_level, 1'b1);
        chk("held_release", btn_release, 1'b0);

        // Release with one-edge bounce: single release after 5th steady low edge
        b = cyc;
        btn_in = 1'b0;
        step(2);
        btn_in = 1'b1;
        step(1);
        btn_in = 1'b0;
        push(1'b1, b + 10);
        step(6);
        chk("bounce_level_held", btn_level, 1'b1);
        step(1);
        chk("release_level", btn_level, 1'b0);
        step(5);

        // Glitches of 3 and 4 edges are rejected
        for (int len = 3; len <= 4; len++) begin
            btn_in = 1'b1;
            step(len);
            btn_in = 1'b0;
            step(12);
            chk("glitch_level", btn_level, 1'b0);
        end

        // Minimum accepted press: 5 edges high
        b = cyc;
        btn_in = 1'b1;
        step(5);
        btn_in = 1'b0;
        push(1'b0, b + 7);
        push(1'b1, b + 12);
        step(2);
        chk("minpress_level", btn_level, 1'b1);
        step(4);
        chk("minpress_level_hold", btn_level, 1'b1);
        step(1);
        chk("minpress_release_level", btn_level, 1'b0);
        step(3);

        // Auto-repeat: pulses at 7, 17, 20; repeat_en low from edge 21 kills 23
        repeat_en = 1'b1;
        b = cyc;
        btn_in = 1'b1;
        push(1'b0, b + 7);
        push(1'b0, b + 17);
        push(1'b0, b + 20);
        step(20);
        repeat_en = 1'b0;
        step(3);
        chk("repeat_off_level", btn_level, 1'b1);
        step(7);

        // Reset mid-REPEAT, then button still held is a fresh press
        b = cyc;
        repeat_en = 1'b1;
        push(1'b0, b + 10);
        step(11);
        rst = 1'b1;
        step(1);
        chk("midrst_level", btn_level, 1'b0);
        chk("midrst_pulse", btn_pulse, 1'b0);
        chk("midrst_release", btn_release, 1'b0);
        rst = 1'b0;
        push(1'b0, b + 19);
        step(6);
        chk("repress_level_before", btn_level, 1'b0);
        step(1);
        chk("repress_level", btn_level, 1'b1);
        repeat_en = 1'b0;
        b = cyc;
        btn_in = 1'b0;
        push(1'b1, b + 7);
        step(7);
        chk("final_release_level", btn_level, 1'b0);
        step(3);

        // Randomized bouncy sweep against the reference model
        rst = 1'b1;
        step(2);
        sweep_on = 1'b1;
        rst = 1'b0;
        seg = 0;
        for (int i = 0; i < 10000; i++) begin
            if (seg == 0) begin
                seg    = int'($urandom_range(1, 40));
                btn_in = ~btn_in;
            end
            seg = seg - 1;
            if ($urandom_range(0, 63) == 0) repeat_en = ~repeat_en;
            rst = ($urandom_range(0, 1999) == 0);
            step(1);
        end
        rst    = 1'b0;
        btn_in = 1'b0;
        step(20);
        total = total + 1;
        if (evq.size() != 0) begin
            bad = bad + 1;
            $display("FAIL leftover_events: got %0d pending, want 0", evq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
